// File: rtl/phimap_term_sched.sv
// phimap_term_sched: serialises one log-domain functional-link expansion per
// input sample onto a single shared log-sin/log-cos LUT port. Term 0 is the
// log|x| value; terms 1..Q_ORD-1 alternate sin/cos of each harmonic angle map.
// Optional feature macro: PHIMAP_SKIP_DEGENERATE_EN. When defined, trig terms
// whose value is log(0) skip the LUT round trip and are emitted directly.
module phimap_term_sched #(
    parameter int Q_ORD     = 7,
    parameter int LUT_WIDTH = 7,
    parameter int LOG_WIDTH = 17,
    parameter int LUT_DW    = 16,
    localparam int H        = (Q_ORD - 1) / 2,
    localparam int IDX_W    = $clog2(Q_ORD)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LOG_WIDTH-1:0]     in_log,
    input  logic                     in_log_sign,
    input  logic                     in_log_nz,
    input  logic [H*LUT_WIDTH-1:0]   in_map,
    input  logic [2*H-1:0]           in_trig_sign,
    output logic                     lut_en,
    output logic [LUT_WIDTH-1:0]     lut_addr,
    output logic                     lut_cos,
    input  logic [LUT_DW-1:0]        lut_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LOG_WIDTH-1:0]     out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_sign,
    output logic                     out_nz,
    output logic                     out_last
);

    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(Q_ORD - 1);
    // Angle map value at which cos is zero (quarter turn), so log-cos is -inf.
    localparam logic [LUT_WIDTH-1:0] COS_NULL = LUT_WIDTH'(1) << (LUT_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, CAPTURE, EMIT} state_t;

    state_t                   state_q, state_d;
    logic                     in_ready_q, in_ready_d;
    logic [H*LUT_WIDTH-1:0]   map_q, map_d;
    logic [2*H-1:0]           trig_sign_q, trig_sign_d;
    logic                     lut_en_q, lut_en_d;
    logic [LUT_WIDTH-1:0]     lut_addr_q, lut_addr_d;
    logic                     lut_cos_q, lut_cos_d;
    logic                     out_valid_q, out_valid_d;
    logic [LOG_WIDTH-1:0]     out_data_q, out_data_d;
    logic [IDX_W-1:0]         out_idx_q, out_idx_d;
    logic                     out_sign_q, out_sign_d;
    logic                     out_nz_q, out_nz_d;
    logic                     out_last_q, out_last_d;

    logic [IDX_W-1:0]         next_idx;
    logic [LUT_WIDTH-1:0]     next_map;
    logic                     next_cos;
    logic [LUT_WIDTH-1:0]     cur_map;
    logic                     cur_cos;

    // Term idx >= 1 belongs to harmonic (idx-1)>>1; odd idx is sin, even is cos.
    function automatic logic [LUT_WIDTH-1:0] harmonic_map(
        input logic [H*LUT_WIDTH-1:0] maps,
        input logic [IDX_W-1:0]       idx
    );
        logic [IDX_W-1:0] h;
        h = (idx - IDX_W'(1)) >> 1;
        return maps[int'(h)*LUT_WIDTH +: LUT_WIDTH];
    endfunction

    function automatic logic is_degenerate(
        input logic [LUT_WIDTH-1:0] m,
        input logic                 use_cos
    );
        return use_cos ? (m == COS_NULL) : (m == '0);
    endfunction

    assign next_idx = out_idx_q + IDX_W'(1);
    assign next_map = harmonic_map(map_q, next_idx);
    assign next_cos = ~next_idx[0];
    assign cur_map  = harmonic_map(map_q, out_idx_q);
    assign cur_cos  = ~out_idx_q[0];

    // Next-state and next-output computation for the term sequencer.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        map_d       = map_q;
        trig_sign_d = trig_sign_q;
        lut_en_d    = 1'b0;
        lut_addr_d  = lut_addr_q;
        lut_cos_d   = lut_cos_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_sign_d  = out_sign_q;
        out_nz_d    = out_nz_q;
        out_last_d  = out_last_q;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_ready_q && in_valid) begin
                    map_d       = in_map;
                    trig_sign_d = in_trig_sign;
                    out_data_d  = in_log;
                    out_sign_d  = in_log_sign;
                    out_nz_d    = in_log_nz;
                    out_idx_d   = '0;
                    out_last_d  = 1'b0;
                    out_valid_d = 1'b1;
                    in_ready_d  = 1'b0;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_idx_q == LAST_IDX) begin
                        in_ready_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        out_idx_d  = next_idx;
                        lut_en_d   = 1'b1;
                        lut_addr_d = next_map;
                        lut_cos_d  = next_cos;
                        state_d    = LOOKUP;
`ifdef PHIMAP_SKIP_DEGENERATE_EN
                        if (is_degenerate(next_map, next_cos)) begin
                            lut_en_d    = 1'b0;
                            lut_addr_d  = lut_addr_q;
                            lut_cos_d   = lut_cos_q;
                            out_data_d  = '0;
                            out_nz_d    = 1'b0;
                            out_sign_d  = trig_sign_q[next_idx - IDX_W'(1)];
                            out_last_d  = (next_idx == LAST_IDX);
                            out_valid_d = 1'b1;
                            state_d     = EMIT;
                        end
`endif
                    end
                end
            end
            LOOKUP: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                out_data_d  = {{(LOG_WIDTH-LUT_DW){lut_data[LUT_DW-1]}}, lut_data};
                out_sign_d  = trig_sign_q[out_idx_q - IDX_W'(1)];
                out_nz_d    = ~is_degenerate(cur_map, cur_cos);
                out_last_d  = (out_idx_q == LAST_IDX);
                out_valid_d = 1'b1;
                state_d     = EMIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any in-flight sample.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            map_q       <= '0;
            trig_sign_q <= '0;
            lut_en_q    <= 1'b0;
            lut_addr_q  <= '0;
            lut_cos_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_sign_q  <= 1'b0;
            out_nz_q    <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            map_q       <= map_d;
            trig_sign_q <= trig_sign_d;
            lut_en_q    <= lut_en_d;
            lut_addr_q  <= lut_addr_d;
            lut_cos_q   <= lut_cos_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_sign_q  <= out_sign_d;
            out_nz_q    <= out_nz_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign lut_en    = lut_en_q;
    assign lut_addr  = lut_addr_q;
    assign lut_cos   = lut_cos_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_sign  = out_sign_q;
    assign out_nz    = out_nz_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_phimap_term_sched.sv
// Testbench for phimap_term_sched: scoreboard of expected terms and LUT
// lookups, fed from a behavioural expansion model, with a decoupled monitor.
module tb_phimap_term_sched;

    localparam int Q_ORD     = 7;
    localparam int LUT_WIDTH = 7;
    localparam int LOG_WIDTH = 17;
    localparam int LUT_DW    = 16;
    localparam int H         = 3;
    localparam int IDX_W     = 3;
`ifdef PHIMAP_SKIP_DEGENERATE_EN
    localparam bit SKIP_DEGEN = 1'b1;
`else
    localparam bit SKIP_DEGEN = 1'b0;
`endif

    typedef struct {
        logic [LOG_WIDTH-1:0] data;
        logic [IDX_W-1:0]     idx;
        logic                 sign;
        logic                 nz;
        logic                 last;
        int                   gap;
    } term_t;

    typedef struct {
        logic [LUT_WIDTH-1:0] addr;
        logic                 use_cos;
    } lookup_t;

    typedef struct {
        logic [LOG_WIDTH-1:0]   log_val;
        logic                   log_sign;
        logic                   log_nz;
        logic [H*LUT_WIDTH-1:0] map;
        logic [2*H-1:0]         trig;
    } sample_t;

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [LOG_WIDTH-1:0]   in_log;
    logic                   in_log_sign;
    logic                   in_log_nz;
    logic [H*LUT_WIDTH-1:0] in_map;
    logic [2*H-1:0]         in_trig_sign;
    logic                   lut_en;
    logic [LUT_WIDTH-1:0]   lut_addr;
    logic                   lut_cos;
    logic [LUT_DW-1:0]      lut_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LOG_WIDTH-1:0]   out_data;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_sign;
    logic                   out_nz;
    logic                   out_last;

    logic [LUT_DW-1:0] sinTab [128];
    logic [LUT_DW-1:0] cosTab [128];

    term_t   expQ[$];
    lookup_t lutQ[$];

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;
    bit busy    = 1'b0;
    int anchor  = 0;
    bit newTerm = 1'b0;
    bit prevResetLow = 1'b0;
    int readyMode = 0;
    int stallCnt  = 0;

    phimap_term_sched #(
        .Q_ORD(Q_ORD), .LUT_WIDTH(LUT_WIDTH), .LOG_WIDTH(LOG_WIDTH), .LUT_DW(LUT_DW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_log(in_log), .in_log_sign(in_log_sign), .in_log_nz(in_log_nz),
        .in_map(in_map), .in_trig_sign(in_trig_sign),
        .lut_en(lut_en), .lut_addr(lut_addr), .lut_cos(lut_cos), .lut_data(lut_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_sign(out_sign), .out_nz(out_nz), .out_last(out_last)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter, bumped on every rising edge so the monitor can time terms.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Behavioural expansion: term 0 is the log value, term k>=1 is sin (odd k)
    // or cos (even k) of harmonic (k-1)/2, looked up in the table model.
    function automatic int pushExpected(input sample_t s);
        term_t   t;
        lookup_t l;
        int      period;
        t.data = s.log_val;
        t.idx  = '0;
        t.sign = s.log_sign;
        t.nz   = s.log_nz;
        t.last = 1'b0;
        t.gap  = 1;
        expQ.push_back(t);
        period = 1;
        for (int k = 1; k < Q_ORD; k++) begin
            int                   h;
            bit                   useCos;
            bit                   degen;
            logic [LUT_WIDTH-1:0] m;
            logic [LUT_DW-1:0]    v;
            h      = (k - 1) / 2;
            useCos = (k % 2 == 0);
            m      = s.map[h*LUT_WIDTH +: LUT_WIDTH];
            degen  = useCos ? (m == 7'd64) : (m == 7'd0);
            t.idx  = IDX_W'(k);
            t.sign = s.trig[k-1];
            t.last = (k == Q_ORD - 1);
            if (SKIP_DEGEN && degen) begin
                t.data = '0;
                t.nz   = 1'b0;
                t.gap  = 1;
            end else begin
                v         = useCos ? cosTab[m] : sinTab[m];
                t.data    = {v[LUT_DW-1], v};
                t.nz      = !degen;
                t.gap     = 3;
                l.addr    = m;
                l.use_cos = useCos;
                lutQ.push_back(l);
            end
            expQ.push_back(t);
            period += t.gap;
        end
        return period + 1;
    endfunction

    function automatic sample_t genSample();
        sample_t s;
        s.log_val  = LOG_WIDTH'($urandom);
        s.log_sign = 1'($urandom);
        s.log_nz   = ($urandom_range(0, 7) != 0);
        s.trig     = 6'($urandom);
        for (int h = 0; h < H; h++) begin
            int r;
            r = $urandom_range(0, 7);
            s.map[h*LUT_WIDTH +: LUT_WIDTH] = (r < 2) ? 7'd0 : (r < 4) ? 7'd64 : 7'($urandom);
        end
        return s;
    endfunction

    // Present a snapshot and wait (bounded) for it to be accepted; the
    // expected terms are queued at the moment the handshake is seen.
    task automatic applyStimulus(input sample_t s, input bit hold, output int accCyc, output int period);
        int waitCnt;
        waitCnt      = 0;
        accCyc       = -1;
        period       = 0;
        in_log       = s.log_val;
        in_log_sign  = s.log_sign;
        in_log_nz    = s.log_nz;
        in_map       = s.map;
        in_trig_sign = s.trig;
        in_valid     = 1'b1;
        while (accCyc < 0 && waitCnt < 300) begin
            @(negedge clk);
            if (reset && in_ready) begin
                accCyc = cyc;
                period = pushExpected(s);
            end
            waitCnt++;
        end
        if (accCyc < 0) checkOutput("accept_timeout in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0 || busy) checkOutput("drain_timeout pending_terms", 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues();
        checkOutput("rst in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst out_data", 32'(out_data), 32'd0);
        checkOutput("rst out_idx", 32'(out_idx), 32'd0);
        checkOutput("rst out_sign", 32'(out_sign), 32'd0);
        checkOutput("rst out_nz", 32'(out_nz), 32'd0);
        checkOutput("rst out_last", 32'(out_last), 32'd0);
        checkOutput("rst lut_en", 32'(lut_en), 32'd0);
        checkOutput("rst lut_addr", 32'(lut_addr), 32'd0);
        checkOutput("rst lut_cos", 32'(lut_cos), 32'd0);
    endtask

    // LUT memory model: a lookup strobed in one cycle returns its entry in
    // the next cycle; otherwise the data bus carries random junk.
    initial begin
        logic                 pend;
        logic [LUT_WIDTH-1:0] pa;
        logic                 pc;
        lut_data = '0;
        forever begin
            @(negedge clk);
            pend = lut_en;
            pa   = lut_addr;
            pc   = lut_cos;
            @(posedge clk);
            #1;
            if (pend === 1'b1) lut_data = pc ? cosTab[pa] : sinTab[pa];
            else lut_data = LUT_DW'($urandom);
        end
    end

    // Consumer back-pressure: always ready, random, or a 4-cycle stall on term 3.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (out_valid && out_idx == 3'd3 && stallCnt < 4) begin
                        out_ready = 1'b0;
                        stallCnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: checks reset values, in_ready against the busy model, every
    // LUT strobe against the lookup queue, and every valid term against the
    // head of the term queue, including when it appears relative to the
    // previous handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset || prevResetLow) checkResetValues();
            if (!reset) begin
                expQ.delete();
                lutQ.delete();
                busy         = 1'b0;
                newTerm      = 1'b0;
                prevResetLow = 1'b1;
            end else begin
                if (!prevResetLow) checkOutput("in_ready", 32'(in_ready), 32'(!busy));
                if (lut_en) begin
                    if (lutQ.size() == 0) begin
                        checkOutput("unexpected_lookup lut_en", 32'(lut_en), 32'd0);
                    end else begin
                        lookup_t l;
                        l = lutQ.pop_front();
                        checkOutput("lut_addr", 32'(lut_addr), 32'(l.addr));
                        checkOutput("lut_cos", 32'(lut_cos), 32'(l.use_cos));
                    end
                end
                if (out_valid) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_term out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        term_t e;
                        e = expQ[0];
                        if (newTerm) begin
                            checkOutput("term_timing cycle", 32'(cyc), 32'(anchor + e.gap));
                            newTerm = 1'b0;
                        end
                        checkOutput("out_data", 32'(out_data), 32'(e.data));
                        checkOutput("out_idx", 32'(out_idx), 32'(e.idx));
                        checkOutput("out_sign", 32'(out_sign), 32'(e.sign));
                        checkOutput("out_nz", 32'(out_nz), 32'(e.nz));
                        checkOutput("out_last", 32'(out_last), 32'(e.last));
                        if (out_ready) begin
                            void'(expQ.pop_front());
                            anchor  = cyc;
                            newTerm = 1'b1;
                            if (e.last) busy = 1'b0;
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    busy    = 1'b1;
                    anchor  = cyc;
                    newTerm = 1'b1;
                end
                prevResetLow = 1'b0;
            end
        end
    end

    // Test sequence: directed cases first, then randomized traffic.
    initial begin
        sample_t s;
        int      acc;
        int      per;
        int      prevAcc;
        int      prevPer;
        bit      found;

        for (int i = 0; i < 128; i++) begin
            sinTab[i] = LUT_DW'($urandom);
            cosTab[i] = LUT_DW'($urandom);
        end
        sinTab[5] = 16'h8001;

        reset        = 1'b0;
        in_valid     = 1'b0;
        in_log       = '0;
        in_log_sign  = 1'b0;
        in_log_nz    = 1'b0;
        in_map       = '0;
        in_trig_sign = '0;
        readyMode    = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] directed: map {5,20,40}, consumer always ready");
        s.log_val  = 17'h0F000;
        s.log_sign = 1'b0;
        s.log_nz   = 1'b1;
        s.map      = {7'd40, 7'd20, 7'd5};
        s.trig     = 6'b101101;
        applyStimulus(s, 1'b0, acc, per);
        waitDrain();

        $display("[TB] directed: 4-cycle stall on term 3");
        stallCnt  = 0;
        readyMode = 2;
        s.trig    = 6'b010011;
        applyStimulus(s, 1'b0, acc, per);
        waitDrain();
        readyMode = 0;

        $display("[TB] directed: degenerate maps {0,64,10}");
        s.map      = {7'd10, 7'd64, 7'd0};
        s.log_sign = 1'b1;
        s.trig     = 6'b111000;
        applyStimulus(s, 1'b0, acc, per);
        waitDrain();

        $display("[TB] directed: zero input (log not valid)");
        s.log_val = '0;
        s.log_nz  = 1'b0;
        s.map     = {7'd127, 7'd1, 7'd64};
        applyStimulus(s, 1'b0, acc, per);
        waitDrain();

        $display("[TB] random samples with random back-pressure");
        readyMode = 1;
        for (int i = 0; i < 25; i++) begin
            applyStimulus(genSample(), 1'b0, acc, per);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        waitDrain();
        readyMode = 0;

        $display("[TB] in_valid held high, back-to-back samples");
        prevAcc = -1;
        prevPer = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(genSample(), 1'b1, acc, per);
            if (i > 0) checkOutput("accept_period", 32'(acc - prevAcc), 32'(prevPer));
            prevAcc = acc;
            prevPer = per;
        end
        in_valid = 1'b0;
        waitDrain();

        $display("[TB] reset asserted during capture of term 2");
        s        = genSample();
        s.map[6:0] = 7'd33;
        applyStimulus(s, 1'b0, acc, per);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (out_idx == 3'd2 && !out_valid && !lut_en) found = 1'b1;
        end
        if (!found) checkOutput("capture_wait_timeout out_idx", 32'(out_idx), 32'd2);
        #1 reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(genSample(), 1'b0, acc, per);
        waitDrain();

        repeat (5) @(posedge clk);
        checkOutput("leftover_terms", 32'(expQ.size()), 32'd0);
        checkOutput("leftover_lookups", 32'(lutQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/phimap_term_sched.md
# phimap_term_sched

Sequencer that serialises one log-domain functional-link expansion per input sample onto a single shared log-sin/log-cos LUT port. It accepts a registered snapshot of the front-end mapping (log|x|, harmonic angle maps, signs), then steps term index 0..Q_ORD-1. For each trigonometric term it issues one LUT lookup and captures the result. Each term is emitted on a valid/ready stream toward the adaptive-filter weight-update path, replacing Q_ORD-1 parallel LUT ports with one.

## Interface
- Q_ORD, 7: expansion order; odd, ≥3; H=(Q_ORD-1)/2 harmonics
- LUT_WIDTH, 7: angle-map address width
- LOG_WIDTH, 17: output term width (Q5.12 log domain)
- LUT_DW, 16: shared LUT data width (signed)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  sample snapshot valid
- in_ready  out  1  block can accept a snapshot
- in_log  in  LOG_WIDTH  log2|x| term (term 0)
- in_log_sign  in  1  sign of x
- in_log_nz  in  1  log term valid (x≠0)
- in_map  in  H*LUT_WIDTH  angle map per harmonic, harmonic h at [h*LUT_WIDTH+:LUT_WIDTH]
- in_trig_sign  in  2*H  sign per trig term, bit 2h = sin(h), bit 2h+1 = cos(h)
- lut_en  out  1  lookup strobe
- lut_addr  out  LUT_WIDTH  LUT address
- lut_cos  out  1  0 = log-sin table, 1 = log-cos table
- lut_data  in  LUT_DW  LUT result, valid exactly one cycle after lut_en
- out_valid  out  1  term valid
- out_ready  in  1  consumer accepts term
- out_data  out  LOG_WIDTH  term value
- out_idx  out  clog2(Q_ORD)  term index
- out_sign  out  1  term sign
- out_nz  out  1  term non-degenerate (log not −∞)
- out_last  out  1  high with idx Q_ORD-1

## Operation
- FSM states: IDLE, LOOKUP, CAPTURE, EMIT.
- IDLE: in_ready=1. On in_valid, register all in_* fields, load term 0 into output regs (out_data=in_log, out_sign=in_log_sign, out_nz=in_log_nz, idx=0), go EMIT.
- EMIT: out_valid=1; outputs stable until out_ready.
  - On out_ready with idx=Q_ORD-1: go IDLE.
  - On out_ready otherwise: idx+1, go LOOKUP.
- LOOKUP: lut_en=1, lut_addr=map[h], h=(idx-1)>>1, lut_cos=~idx[0] (odd idx = sin, even = cos). Go CAPTURE.
- CAPTURE: out_data = sign-extend(lut_data) to LOG_WIDTH; out_sign = in_trig_sign[idx-1].
  - out_nz = (map[h]≠0) for sin; out_nz = (map[h]≠2^(LUT_WIDTH-1)) for cos.
  - Go EMIT.
- lut_en=0 in every state except LOOKUP; lut_addr/lut_cos hold their last value.
- in_valid outside IDLE is ignored (in_ready=0); the snapshot is never overwritten mid-sequence.
- Reset outputs: in_ready=0 while reset low, 1 on first cycle after release; out_valid=0, out_data=0, out_idx=0, out_sign=0, out_nz=0, out_last=0, lut_en=0, lut_addr=0, lut_cos=0; state IDLE.
- Reset mid-sequence: in-flight sample discarded; no further terms emitted.

## Timing
- Snapshot accepted at cycle t: term 0 has out_valid at t+1.
- With out_ready held high, term k≥1 appears at t+1+3k. Last term (Q_ORD=7) at t+19; IDLE, next accept at t+20. Sample period is 20 cycles.
- Backpressure stalls only in EMIT and adds cycle-for-cycle.
- out_last = (out_idx==Q_ORD-1) whenever out_valid.

## Configuration
- PHIMAP_SKIP_DEGENERATE_EN defined: in EMIT→next-term transition, if the next trig term is degenerate (sin with map=0, cos with map=2^(LUT_WIDTH-1)), skip LOOKUP/CAPTURE. Load out_data=0 and out_nz=0 and go directly to EMIT. This saves 2 cycles per degenerate term; lut_en stays low for it.
- Undefined: every trig term performs a lookup, and the timing above holds exactly.

## Test plan
- Reset release, then in_valid with in_log=0x0F000, map={5,20,40}, out_ready=1 → term0 at t+1 = 0x0F000; lut_addr sequence 5,5,20,20,40,40 with lut_cos 0,1,0,1,0,1; out_last only on idx 6 at t+19.
- out_ready low 4 cycles during term 3 → term 3 data/idx held stable; term 6 at t+23; exactly 7 handshakes.
- map={0,64,10} (LUT_WIDTH=7) → idx1 out_nz=0, idx4 out_nz=0, others 1. With PHIMAP_SKIP_DEGENERATE_EN, idx1/idx4 out_data=0, no lut_en for them, term 6 at t+15.
- lut_data=0x8001 → out_data=0x18001 (sign-extended); out_sign equals in_trig_sign bit idx-1.
- in_valid held high throughout → in_ready only in IDLE; back-to-back accepts 20 cycles apart.
- reset low during CAPTURE of term 2 → next cycle all outputs at reset values; after release, new sample starts from idx 0.
